// File: rtl/truth_table_sweeper.sv
// Exhaustive 4-input truth-table sweeper: drives A-D through 0..15, samples Q, compares with exp_tt.
// Optional build macro SWEEP_STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
module truth_table_sweeper #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] exp_tt,
  input  logic        Q,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] tt,
  output logic [4:0]  mismatch_cnt,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  // Handshake: start is a level sampled only in IDLE, abort only in DRIVE;
  // done is a one-cycle pulse and results stay valid until the next accepted start.
  state_t      state;
  logic [3:0]  vec;
  logic [7:0]  hold_cnt;
  logic [15:0] exp_lat;
  logic        last_hold;
  logic        sample_miss;
  logic        end_sweep;

  assign last_hold   = (hold_cnt == HOLD_LAST);
  assign sample_miss = (Q != exp_lat[vec]);
  assign state_dbg   = state;

`ifdef SWEEP_STOP_ON_FAIL_EN
  assign end_sweep = (vec == 4'd15) || sample_miss;
`else
  assign end_sweep = (vec == 4'd15);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      vec          <= 4'd0;
      hold_cnt     <= 8'd0;
      exp_lat      <= 16'h0000;
      {A, B, C, D} <= 4'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      tt           <= 16'h0000;
      mismatch_cnt <= 5'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_DRIVE;
            tt           <= 16'h0000;
            mismatch_cnt <= 5'd0;
            pass         <= 1'b0;
            exp_lat      <= exp_tt;
            vec          <= 4'd0;
            hold_cnt     <= 8'd0;
            {A, B, C, D} <= 4'd0;
            busy         <= 1'b1;
          end
        end
        S_DRIVE: begin
          // Abort outranks the sample edge, so the last vector is never recorded.
          if (abort) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            pass         <= 1'b0;
            {A, B, C, D} <= 4'd0;
            vec          <= 4'd0;
            hold_cnt     <= 8'd0;
          end else if (last_hold) begin
            tt[vec]  <= Q;
            hold_cnt <= 8'd0;
            if (sample_miss) begin
              mismatch_cnt <= mismatch_cnt + 5'd1;
            end
            if (end_sweep) begin
              state        <= S_DONE;
              done         <= 1'b1;
              busy         <= 1'b0;
              pass         <= (mismatch_cnt == 5'd0) && !sample_miss;
              {A, B, C, D} <= 4'd0;
              vec          <= 4'd0;
            end else begin
              vec          <= vec + 4'd1;
              {A, B, C, D} <= vec + 4'd1;
            end
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: directed sweeps with hand-computed truth tables.
module tb_truth_table_sweeper;

  localparam int H = 4;
  localparam int FULL = 16 * H;
  localparam int W = 54;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] exp_tt = 16'h0000;
  logic        Q;
  logic        A, B, C, D;
  logic        busy, done, pass;
  logic [15:0] tt;
  logic [4:0]  mismatch_cnt;
  logic [1:0]  state_dbg;

  int mode = 0;
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  int sweep_k = 0;
  int sweep_len = 0;
  bit sweep_active = 1'b0;

  // {done cycle[31:0], tt[15:0], mismatch_cnt[4:0], pass}
  logic [W-1:0] exp_q[$];

  truth_table_sweeper #(.HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .exp_tt(exp_tt), .Q(Q),
    .A(A), .B(B), .C(C), .D(D), .busy(busy), .done(done), .pass(pass),
    .tt(tt), .mismatch_cnt(mismatch_cnt), .state_dbg(state_dbg)
  );

  // clock / edge counter: after edge k, cyc == k; the cycle after edge k is cycle k+1
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // combinational unit under lab test
  always_comb begin
    case (mode)
      0:       Q = A & B & C & D;
      1:       Q = A ^ B ^ C ^ D;
      default: Q = 1'b1;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    int cur;
    logic [W-1:0] e;
    cur = cyc + 1;
    if (!rst) begin
      if (sweep_active && cur >= sweep_k + 1 && cur <= sweep_k + sweep_len) begin
        check("abcd_drive", 32'({A, B, C, D}), 32'((cur - sweep_k - 1) / H));
        check("busy_drive", 32'(busy), 32'd1);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_done: got done=1 in cycle %0d expected no done", cur);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", 32'(cur), e[53:22]);
          check("tt", 32'(tt), 32'(e[21:6]));
          check("mismatch_cnt", 32'(mismatch_cnt), 32'(e[5:1]));
          check("pass", 32'(pass), 32'(e[0]));
          check("busy_done", 32'(busy), 32'd0);
          check("abcd_done", 32'({A, B, C, D}), 32'd0);
        end
      end
    end
  end

  // driver tasks
  task automatic start_sweep(input int m, input logic [15:0] e, input int len);
    @(negedge clk);
    mode = m;
    exp_tt = e;
    sweep_len = len;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sweep_k = cyc;
    sweep_active = 1'b1;
  endtask

  task automatic expect_done(input logic [15:0] rtt, input logic [4:0] cnt, input logic p);
    logic [31:0] dc;
    dc = 32'(sweep_k + sweep_len + 1);
    exp_q.push_back({dc, rtt, cnt, p});
  endtask

  task automatic drain(input string name);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s: got %0d pending results expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_full(input int m, input logic [15:0] e, input logic [15:0] rtt,
                          input logic [4:0] cnt, input logic p, input int len);
    start_sweep(m, e, len);
    expect_done(rtt, cnt, p);
    repeat (len + 3) @(posedge clk);
    sweep_active = 1'b0;
    drain("done_timeout");
  endtask

  task automatic run_abort(input int m, input logic [15:0] e, input int at_cycle,
                           input logic [15:0] rtt, input logic [4:0] cnt);
    start_sweep(m, e, FULL);
    repeat (at_cycle) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    sweep_active = 1'b0;
    @(negedge clk);
    check("abort_abcd", 32'({A, B, C, D}), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_pass", 32'(pass), 32'd0);
    check("abort_tt", 32'(tt), 32'(rtt));
    check("abort_cnt", 32'(mismatch_cnt), 32'(cnt));
    check("abort_state", 32'(state_dbg), 32'd0);
    repeat (FULL + 4) @(posedge clk);
  endtask

  task automatic run_restarts();
    start_sweep(0, 16'h8000, FULL);
    expect_done(16'h8000, 5'd0, 1'b1);
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // pulse start again in the DONE cycle
    for (int i = 0; i < FULL + 8 && (cyc + 1) < sweep_k + FULL + 1; i++) @(negedge clk);
    if ((cyc + 1) != sweep_k + FULL + 1) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sweep_active = 1'b0;
    @(negedge clk);
    check("restart_busy", 32'(busy), 32'd0);
    check("restart_state", 32'(state_dbg), 32'd0);
    repeat (FULL + 8) @(posedge clk);
    drain("restart_done_timeout");
    check("restart_idle", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_abcd"}, 32'({A, B, C, D}), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_tt"}, 32'(tt), 32'd0);
    check({tag, "_cnt"}, 32'(mismatch_cnt), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;

    run_full(0, 16'h8000, 16'h8000, 5'd0, 1'b1, FULL);
    run_full(1, 16'h6996, 16'h6996, 5'd0, 1'b1, FULL);
`ifdef SWEEP_STOP_ON_FAIL_EN
    run_full(1, 16'h6997, 16'h0000, 5'd1, 1'b0, H);
    run_full(2, 16'h0000, 16'h0001, 5'd1, 1'b0, H);
`else
    run_full(1, 16'h6997, 16'h6996, 5'd1, 1'b0, FULL);
    run_full(2, 16'h0000, 16'hFFFF, 5'd16, 1'b0, FULL);
`endif
    run_full(0, 16'h8000, 16'h8000, 5'd0, 1'b1, FULL);

    // abort during vector 5 (cycles k+21..k+24), seen at edge k+22
    run_abort(0, 16'h8000, 22, 16'h0000, 5'd0);
    run_abort(1, 16'h6996, 22, 16'h0016, 5'd0);
    // abort on the final sample edge of vector 15
    run_abort(0, 16'h8000, FULL, 16'h0000, 5'd0);

    run_restarts();

    // asynchronous reset mid-sweep, between clock edges
    start_sweep(1, 16'h6996, FULL);
    repeat (30) @(negedge clk);
    sweep_active = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    rst = 1'b0;
    run_full(0, 16'h8000, 16'h8000, 5'd0, 1'b1, FULL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
